// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D,
    ERR_D
  } arb_state_e;

  localparam logic [3:0] UNIT_B = 4'b0001;
  localparam logic [3:0] UNIT_H = 4'b0010;
  localparam logic [3:0] UNIT_W = 4'b0100;
  localparam logic [3:0] UNIT_D = 4'b1000;

  // An access is misaligned when its byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] offset, input logic [3:0] unit);
    logic mis;
    mis = 1'b0;
    case (unit)
      UNIT_H:  mis = offset[0];
      UNIT_W:  mis = |offset[1:0];
      UNIT_D:  mis = |offset;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side buses of the shared memory port, plus pipeline stalls.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_be;
  logic [3:0]  d_unit;
  logic        d_ext;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be, d_unit, d_ext,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be, d_unit, d_ext,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_load_align.sv
// Right-aligns load data by byte offset and sign/zero-extends it to 64 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [3:0]  unit,
  input  logic        ext,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (unit)
      UNIT_B:  data = {{56{ext & shifted[7]}},  shifted[7:0]};
      UNIT_H:  data = {{48{ext & shifted[15]}}, shifted[15:0]};
      UNIT_W:  data = {{32{ext & shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM stage,
// one outstanding transaction at a time, with fetch-starvation protection.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned FETCH_STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

  arb_state_e  state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic [2:0]  off_q;
  logic [3:0]  unit_q;
  logic        ext_q, we_q, word_q;
  logic        d_grant, i_grant, pick_d, misaligned;
  logic        if_rvalid_c, d_rvalid_c;
  logic [63:0] load_data;
  logic        unused_if_addr;

  assign unused_if_addr = ^bus.if_addr[1:0];

  mem_load_align u_align (
    .rdata  (bus.mem_rdata),
    .offset (off_q),
    .unit   (unit_q),
    .ext    (ext_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      unit_q <= '0;
      ext_q  <= 1'b0;
      we_q   <= 1'b0;
      word_q <= 1'b0;
    end else begin
      if (d_grant) begin
        off_q  <= bus.d_addr[2:0];
        unit_q <= bus.d_unit;
        ext_q  <= bus.d_ext;
        we_q   <= bus.d_we;
      end
      if (i_grant) word_q <= bus.if_addr[2];
    end
  end

  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    d_grant       = 1'b0;
    i_grant       = 1'b0;
    if_rvalid_c   = 1'b0;
    d_rvalid_c    = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    bus.d_err     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    misaligned    = is_misaligned(bus.d_addr[2:0], bus.d_unit);
    pick_d        = bus.d_req && !(bus.if_req && starve_cnt == STARVE_MAX);

    case (state)
      IDLE: begin
        // Arbitration outputs are suppressed while reset is held.
        if (rst_n) begin
          if (pick_d) begin
            if (misaligned) begin
              d_grant   = 1'b1;
              state_nxt = ERR_D;
            end else begin
              bus.mem_req   = 1'b1;
              bus.mem_we    = bus.d_we;
              bus.mem_addr  = {bus.d_addr[63:3], 3'b000};
              bus.mem_wdata = bus.d_wdata;
              bus.mem_be    = bus.d_be;
              d_grant       = bus.mem_gnt;
              if (bus.mem_gnt) state_nxt = WAIT_D;
            end
          end else if (bus.if_req) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {bus.if_addr[63:3], 3'b000};
            i_grant      = bus.mem_gnt;
            if (bus.mem_gnt) state_nxt = WAIT_I;
          end

          if (!bus.if_req || i_grant) starve_nxt = '0;
          else if (d_grant && starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + 4'd1;
        end
      end
      WAIT_I: begin
        if_rvalid_c  = bus.mem_rvalid;
        bus.if_rdata = word_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        if (bus.mem_rvalid) state_nxt = IDLE;
      end
      WAIT_D: begin
        d_rvalid_c  = bus.mem_rvalid;
        bus.d_rdata = we_q ? '0 : load_data;
        if (bus.mem_rvalid) state_nxt = IDLE;
      end
      ERR_D: begin
        d_rvalid_c = 1'b1;
        bus.d_err  = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    bus.if_gnt    = i_grant;
    bus.d_gnt     = d_grant;
    bus.if_rvalid = if_rvalid_c;
    bus.d_rvalid  = d_rvalid_c;
    bus.stall_if  = bus.if_req & ~if_rvalid_c;
    bus.stall_mem = bus.d_req & ~d_rvalid_c;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned MAX = 4;

  logic clk = 1'b0;
  logic rst_n;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.FETCH_STARVE_MAX(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          fetch;
    bit          err;
    bit          we;
    bit          ext;
    int unsigned off;
    int unsigned nbytes;
    bit          word;
  } txn_t;

  txn_t        pend[$];
  int unsigned starve = 0;

  function automatic int unsigned unit_bytes(input logic [3:0] u);
    case (u)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] ext_load(input logic [63:0] raw, input int unsigned off,
                                           input int unsigned nbytes, input bit sx);
    logic [63:0] v;
    int unsigned sh;
    sh = 64 - 8 * nbytes;
    v  = (raw >> (8 * off)) << sh;
    if (sx) v = 64'($signed(v) >>> sh);
    else    v = v >> sh;
    return v;
  endfunction

  always @(negedge clk) begin
    logic        e_ig, e_dg, e_ir, e_dr, e_de, e_mreq, e_mwe;
    logic [63:0] e_maddr, e_mwdata, e_drdata;
    logic [7:0]  e_mbe;
    logic [31:0] e_irdata;
    txn_t        t;
    e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_de = 0; e_mreq = 0; e_mwe = 0;
    e_maddr = 0; e_mwdata = 0; e_drdata = 0; e_mbe = 0; e_irdata = 0;

    if (!rst_n) begin
      pend.delete();
      starve = 0;
    end else if (pend.size() == 0) begin
      bit take_d;
      take_d = bus.d_req && !(bus.if_req && starve == MAX);
      if (take_d) begin
        t.fetch  = 0;
        t.we     = bus.d_we;
        t.ext    = bus.d_ext;
        t.off    = int'(bus.d_addr[2:0]);
        t.nbytes = unit_bytes(bus.d_unit);
        t.word   = 0;
        t.err    = (t.off % t.nbytes) != 0;
        if (t.err) e_dg = 1;
        else begin
          e_mreq   = 1;
          e_mwe    = bus.d_we;
          e_maddr  = bus.d_addr & ~64'h7;
          e_mwdata = bus.d_wdata;
          e_mbe    = bus.d_be;
          e_dg     = bus.mem_gnt;
        end
        if (e_dg) begin
          pend.push_back(t);
          if (bus.if_req && starve < MAX) starve++;
        end
      end else if (bus.if_req) begin
        e_mreq  = 1;
        e_maddr = bus.if_addr & ~64'h7;
        e_ig    = bus.mem_gnt;
        if (e_ig) begin
          t.fetch = 1; t.err = 0; t.we = 0; t.ext = 0; t.off = 0; t.nbytes = 4;
          t.word  = bus.if_addr[2];
          pend.push_back(t);
          starve = 0;
        end
      end
      if (!bus.if_req) starve = 0;
    end else begin
      t = pend[0];
      if (t.err) begin
        e_dr = 1; e_de = 1; e_drdata = 0;
        pend.delete(0);
      end else if (t.fetch) begin
        e_ir     = bus.mem_rvalid;
        e_irdata = 32'(bus.mem_rdata >> (t.word ? 32 : 0));
        if (bus.mem_rvalid) pend.delete(0);
      end else begin
        e_dr     = bus.mem_rvalid;
        e_drdata = t.we ? 64'h0 : ext_load(bus.mem_rdata, t.off, t.nbytes, t.ext);
        if (bus.mem_rvalid) pend.delete(0);
      end
    end

    chk("if_gnt",    bus.if_gnt,    e_ig);
    chk("d_gnt",     bus.d_gnt,     e_dg);
    chk("if_rvalid", bus.if_rvalid, e_ir);
    chk("d_rvalid",  bus.d_rvalid,  e_dr);
    chk("d_err",     bus.d_err,     e_de);
    chk("mem_req",   bus.mem_req,   e_mreq);
    chk("stall_if",  bus.stall_if,  bus.if_req & ~e_ir);
    chk("stall_mem", bus.stall_mem, bus.d_req & ~e_dr);
    if (!rst_n) begin
      chk("rst_mem_addr", bus.mem_addr, 64'h0);
      chk("rst_d_rdata",  bus.d_rdata,  64'h0);
    end
    if (e_mreq) begin
      chk("mem_we",   bus.mem_we,   e_mwe);
      chk("mem_addr", bus.mem_addr, e_maddr);
      if (e_mwe) begin
        chk("mem_wdata", bus.mem_wdata, e_mwdata);
        chk("mem_be",    bus.mem_be,    e_mbe);
      end
    end
    if (e_ir) chk("if_rdata", bus.if_rdata, e_irdata);
    if (e_dr) chk("d_rdata",  bus.d_rdata,  e_drdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit fetch, output int waited);
    bit ok;
    ok     = 0;
    waited = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = fetch ? bus.if_gnt : bus.d_gnt;
      if (!ok) begin
        waited++;
        tick();
      end
    end
    chk(fetch ? "if_gnt_timeout" : "d_gnt_timeout", ok, 1);
  endtask

  task automatic fetch_txn(input logic [63:0] addr, input logic [63:0] rdata,
                           output logic [31:0] got, output logic got_v, output int waited);
    bus.if_req = 1; bus.if_addr = addr; bus.mem_gnt = 1;
    wait_gnt(1, waited);
    tick();
    bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = rdata;
    @(negedge clk);
    got   = bus.if_rdata;
    got_v = bus.if_rvalid;
    tick();
    bus.mem_rvalid = 0;
  endtask

  task automatic data_txn(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                          input logic [7:0] be, input logic [3:0] unit, input logic ext,
                          input logic [63:0] rdata, output logic [63:0] got,
                          output logic got_err, output logic got_v, output int waited);
    bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
    bus.d_unit = unit; bus.d_ext = ext; bus.mem_gnt = 1;
    wait_gnt(0, waited);
    tick();
    bus.d_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = rdata;
    @(negedge clk);
    got     = bus.d_rdata;
    got_err = bus.d_err;
    got_v   = bus.d_rvalid;
    tick();
    bus.mem_rvalid = 0;
  endtask

  initial begin
    logic [31:0] r32;
    logic [63:0] r64;
    logic        v, e, g;
    logic [9:0]  seq;
    int          w, ngnt, both;

    rst_n = 0;
    bus.if_req = 1; bus.if_addr = 64'h1000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h2000; bus.d_wdata = 0; bus.d_be = 0;
    bus.d_unit = 4'b1000; bus.d_ext = 0;
    bus.mem_gnt = 1; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // Requests pending during reset: no grant, no memory request, stalls follow inputs.
    @(negedge clk);
    chk("rst_gnts", {bus.if_gnt, bus.d_gnt, bus.mem_req}, 3'b000);
    chk("rst_stalls", {bus.stall_if, bus.stall_mem}, 2'b11);
    tick();
    bus.if_req = 0; bus.d_req = 0; bus.mem_gnt = 0;
    tick();
    rst_n = 1;
    tick();

    fetch_txn(64'h1004, 64'hAABBCCDD_11223344, r32, v, w);
    chk("fetch_latency", w, 0);
    chk("fetch_rvalid", v, 1);
    chk("fetch_rdata", r32, 32'hAABBCCDD);

    data_txn(64'h2003, 0, 0, 0, 4'b0001, 1, 64'h00000000_80000000, r64, e, v, w);
    chk("lb_latency", w, 0);
    chk("lb_rdata", r64, 64'hFFFFFFFF_FFFFFF80);
    data_txn(64'h2003, 0, 0, 0, 4'b0001, 0, 64'h00000000_80000000, r64, e, v, w);
    chk("lbu_rdata", r64, 64'h80);
    data_txn(64'h2006, 0, 0, 0, 4'b0010, 1, 64'h8001_0000_0000_0000, r64, e, v, w);
    chk("lh_rdata", r64, 64'hFFFFFFFF_FFFF8001);
    data_txn(64'h2004, 0, 0, 0, 4'b0100, 0, 64'hDEADBEEF_00000000, r64, e, v, w);
    chk("lwu_rdata", r64, 64'h00000000_DEADBEEF);
    data_txn(64'h2000, 0, 0, 0, 4'b1000, 1, 64'h01234567_89ABCDEF, r64, e, v, w);
    chk("ld_rdata", r64, 64'h01234567_89ABCDEF);
    data_txn(64'h2008, 1, 64'h11223344_55667788, 8'hFF, 4'b1000, 0, 64'hFFFF_FFFF_FFFF_FFFF,
             r64, e, v, w);
    chk("sd_ack", v, 1);
    chk("sd_rdata", r64, 64'h0);

    // Both requesters held high: data four times, then fetch.
    bus.if_req = 1; bus.if_addr = 64'h4000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h5000; bus.d_unit = 4'b1000; bus.d_ext = 0;
    bus.mem_gnt = 1; bus.mem_rdata = 64'hCAFEF00D_12345678;
    seq = 0; ngnt = 0; both = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      g = bus.if_gnt | bus.d_gnt;
      if (g) begin
        seq = {seq[8:0], bus.d_gnt};
        ngnt++;
      end
      if (bus.if_gnt && bus.d_gnt) both++;
      tick();
      bus.mem_rvalid = g;
    end
    bus.if_req = 0; bus.d_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
    chk("starve_seq", seq, 10'b1111011110);
    chk("starve_ngnt", ngnt, 10);
    chk("starve_both", both, 0);
    tick();

    data_txn(64'h3001, 0, 0, 0, 4'b0010, 0, 64'hFFFF_FFFF_FFFF_FFFF, r64, e, v, w);
    chk("mis_latency", w, 0);
    chk("mis_rvalid", v, 1);
    chk("mis_err", e, 1);
    chk("mis_rdata", r64, 64'h0);

    // Memory busy for three cycles before accepting.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h6000; bus.d_unit = 4'b0100; bus.d_ext = 0;
    bus.mem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_no_gnt", bus.d_gnt, 0);
      chk("busy_stall", bus.stall_mem, 1);
      tick();
    end
    bus.mem_gnt = 1;
    @(negedge clk);
    chk("busy_gnt4", bus.d_gnt, 1);
    tick();
    bus.d_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 64'h0000_0000_8765_4321;
    @(negedge clk);
    chk("busy_rdata", bus.d_rdata, 64'h8765_4321);
    tick();
    bus.mem_rvalid = 0;

    // Reset in the middle of a load; the late response must be dropped.
    bus.d_req = 1; bus.d_addr = 64'h7000; bus.d_unit = 4'b1000; bus.mem_gnt = 1;
    @(negedge clk);
    chk("rstw_gnt", bus.d_gnt, 1);
    tick();
    bus.d_req = 0; bus.mem_gnt = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    chk("rstw_late_rvalid", bus.d_rvalid, 0);
    tick();
    bus.mem_rvalid = 0;
    fetch_txn(64'h8000, 64'h0BADBEEF_13579BDF, r32, v, w);
    chk("rstw_idle_latency", w, 0);
    chk("rstw_fetch_rdata", r32, 32'h13579BDF);

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d passed of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
